checkin_v2_0_s00_axi_regs: RTL and testbench

//  AXI4-Lite slave register file behind the S00_AXI port of checkin_v2_0.

---
 rtl/checkin_v2_0_s00_axi_regs.sv | 172 +++++++++++++++++
 tb/tb_checkin_v2_0_s00_axi_regs.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkin_v2_0_s00_axi_regs.sv
`default_nettype none
// ============================================================================
// Module   : checkin_v2_0_s00_axi_regs
// Brief    : AXI4-Lite slave register file with byte strobes, register view
//            and per-register write pulses for the checkin_v2_0 S00_AXI port.
// Revision : 1.0 - initial release
// ============================================================================
module checkin_v2_0_s00_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

    localparam int                c_idx_w    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int                c_dw       = C_S_AXI_DATA_WIDTH;
    localparam int                c_sw       = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [c_idx_w:0]  c_num_regs = (c_idx_w + 1)'(NUM_REGS);
    localparam logic [1:0]        c_okay     = 2'b00;
    localparam logic [1:0]        c_slverr   = 2'b10;

    logic                r_active;
    logic                r_aw_held;
    logic [c_idx_w-1:0]  r_aw_idx;
    logic                r_w_held;
    logic [c_dw-1:0]     r_wdata;
    logic [c_sw-1:0]     r_wstrb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [c_dw-1:0]     r_rdata;
    logic [1:0]          r_rresp;
    logic [NUM_REGS-1:0] r_pulse;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_commit;
    logic                w_aw_ok;
    logic                w_ar_ok;
    logic [c_idx_w-1:0]  w_ar_idx;
    logic [c_dw-1:0]     w_rd_mux;
    logic [NUM_REGS-1:0] w_hit;
    logic                w_unused;

    // Readies stay low until the first edge after reset release.
    assign s00_axi_awready = r_active & ~r_aw_held;
    assign s00_axi_wready  = r_active & ~r_w_held;
    assign s00_axi_arready = r_active & ~r_rvalid;

    assign w_aw_hs  = s00_axi_awvalid & s00_axi_awready;
    assign w_w_hs   = s00_axi_wvalid & s00_axi_wready;
    assign w_ar_hs  = s00_axi_arvalid & s00_axi_arready;
    assign w_commit = r_aw_held & r_w_held & ~r_bvalid;
    assign w_aw_ok  = {1'b0, r_aw_idx} < c_num_regs;
    assign w_ar_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_ar_ok  = {1'b0, w_ar_idx} < c_num_regs;
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        localparam logic [c_idx_w-1:0] c_k = c_idx_w'(k);
        logic [c_dw-1:0] r_q;

        assign w_hit[k] = w_commit & (r_aw_idx == c_k);

        always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
            if (!s00_axi_aresetn) begin
                r_q <= '0;
            end else if (w_hit[k]) begin
                for (int b = 0; b < c_sw; b++) begin
                    if (r_wstrb[b]) r_q[8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end

        assign regs_out[k*c_dw +: c_dw] = r_q;
    end

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_ar_idx == c_idx_w'(k)) w_rd_mux = regs_out[k*c_dw +: c_dw];
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_active  <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_okay;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_okay;
            r_pulse   <= '0;
        end else begin
            r_active <= 1'b1;
            r_pulse  <= w_hit;

            // Capture and commit never coincide: a held flag drops its ready.
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end

            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s00_axi_wdata;
                r_wstrb  <= s00_axi_wstrb;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_ok ? c_okay : c_slverr;
            end else if (r_bvalid && s00_axi_bready) begin
                r_bvalid <= 1'b0;
                r_bresp  <= c_okay;
            end

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_ar_ok ? w_rd_mux : '0;
                r_rresp  <= w_ar_ok ? c_okay : c_slverr;
            end else if (r_rvalid && s00_axi_rready) begin
                r_rvalid <= 1'b0;
                r_rdata  <= '0;
                r_rresp  <= c_okay;
            end
        end
    end

    assign s00_axi_bvalid = r_bvalid;
    assign s00_axi_bresp  = r_bresp;
    assign s00_axi_rvalid = r_rvalid;
    assign s00_axi_rdata  = r_rdata;
    assign s00_axi_rresp  = r_rresp;
    assign reg_wr_pulse   = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_checkin_v2_0_s00_axi_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_checkin_v2_0_s00_axi_regs
// Brief    : Scoreboard bench for the S00_AXI register file (4- and 3-register builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_checkin_v2_0_s00_axi_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        awready4, wready4, bvalid4, arready4, rvalid4;
    logic [1:0]  bresp4, rresp4;
    logic [31:0] rdata4;
    logic [127:0] regs_out4;
    logic [3:0]  pulse4;
    logic        awready3, wready3, bvalid3, arready3, rvalid3;
    logic [1:0]  bresp3, rresp3;
    logic [31:0] rdata3;
    logic [95:0] regs_out3;
    logic [2:0]  pulse3;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    assign awready = sel ? awready3 : awready4;
    assign wready  = sel ? wready3  : wready4;
    assign bvalid  = sel ? bvalid3  : bvalid4;
    assign bresp   = sel ? bresp3   : bresp4;
    assign arready = sel ? arready3 : arready4;
    assign rvalid  = sel ? rvalid3  : rvalid4;
    assign rresp   = sel ? rresp3   : rresp4;
    assign rdata   = sel ? rdata3   : rdata4;

    always #5 clk = ~clk;

    checkin_v2_0_s00_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(4)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid & ~sel),
        .s00_axi_awready(awready4),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid & ~sel),
        .s00_axi_wready(wready4),
        .s00_axi_bresp(bresp4), .s00_axi_bvalid(bvalid4), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid & ~sel),
        .s00_axi_arready(arready4),
        .s00_axi_rdata(rdata4), .s00_axi_rresp(rresp4), .s00_axi_rvalid(rvalid4),
        .s00_axi_rready(rready),
        .regs_out(regs_out4), .reg_wr_pulse(pulse4)
    );

    checkin_v2_0_s00_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(3)) dut3 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid & sel),
        .s00_axi_awready(awready3),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid & sel),
        .s00_axi_wready(wready3),
        .s00_axi_bresp(bresp3), .s00_axi_bvalid(bvalid3), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid & sel),
        .s00_axi_arready(arready3),
        .s00_axi_rdata(rdata3), .s00_axi_rresp(rresp3), .s00_axi_rvalid(rvalid3),
        .s00_axi_rready(rready),
        .regs_out(regs_out3), .reg_wr_pulse(pulse3)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];
    logic [31:0] m [2][4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Responses are popped in order as they are handshaken.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (b_q.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", bresp, b_q.pop_front());
        end
        if (rst_n && rvalid && rready) begin
            if (r_q.size() == 0) check("r_unexpected", 1, 0);
            else check("rresp_rdata", {rresp, rdata}, r_q.pop_front());
        end
    end

    function automatic int nregs();
        return sel ? 3 : 4;
    endfunction

    task automatic send_aw(input logic [3:0] a);
        int n;
        n = 0;
        awaddr = a; awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        if (!awready) check("aw_timeout", awready, 1);
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!wready && n < 50);
        if (!wready) check("w_timeout", wready, 1);
        @(posedge clk); #1 wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] a);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) check("ar_timeout", arready, 1);
        @(posedge clk); #1 arvalid = 1'b0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        int si;
        idx = int'(a[3:2]);
        si  = int'(sel);
        if (idx < nregs()) begin
            for (int b = 0; b < 4; b++) if (s[b]) m[si][idx][8*b +: 8] = d[8*b +: 8];
            b_q.push_back(2'b00);
        end else begin
            b_q.push_back(2'b10);
        end
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        model_write(a, d, s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic read(input logic [3:0] a);
        int idx;
        idx = int'(a[3:2]);
        if (idx < nregs()) r_q.push_back({2'b00, m[int'(sel)][idx]});
        else r_q.push_back({2'b10, 32'h0});
        send_ar(a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 100) begin
            @(posedge clk); n++;
        end
        if (b_q.size() != 0 || r_q.size() != 0) check("drain_timeout", b_q.size() + r_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_regs4(input string tag);
        for (int k = 0; k < 4; k++) check(tag, regs_out4[32*k +: 32], m[0][k]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int n;
        rst_n = 1'b0; sel = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        wdata = '0; wstrb = '0;
        for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) m[i][k] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp_rresp_rdata", {bresp, rresp, rdata}, 0);
        check("rst_pulse", pulse4, 0);
        check("rst_regs_out", regs_out4[63:0], 0);
        check("rst_regs_out_hi", regs_out4[127:64], 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: full-word writes then read back
        for (int i = 0; i < 4; i++) begin
            v = 32'(i + 1);
            write(4'(4 * i), v, 4'hF);
        end
        drain();
        for (int i = 0; i < 4; i++) read(4'(4 * i));
        drain();
        check_regs4("t1_regs_out");

        // 2: single byte lane
        write(4'h4, 32'hAABBCCDD, 4'b0010);
        drain();
        read(4'h4);
        drain();
        check("t2_reg1", regs_out4[63:32], 32'h0000CC02);

        // 3: W leads AW by three cycles
        model_write(4'hC, 32'h12345678, 4'hF);
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk) check("t3_wready_pre", wready, 1);
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_wready_held", wready, 0);
            check("t3_no_b", bvalid, 0);
            @(posedge clk); #1;
        end
        awaddr = 4'hC; awvalid = 1'b1;
        @(negedge clk) check("t3_awready", awready, 1);
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        check("t3_b_early", bvalid, 0);
        check("t3_pulse_early", pulse4, 0);
        @(negedge clk);
        check("t3_bvalid", bvalid, 1);
        check("t3_pulse", pulse4, 4'b1000);
        @(negedge clk);
        check("t3_pulse_end", pulse4, 0);
        @(posedge clk); #1;
        drain();
        check_regs4("t3_regs_out");

        // 4: back-pressured B with a second write queued behind it
        bready = 1'b0;
        write(4'h8, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            check("t4_bvalid_hold", bvalid, 1);
            check("t4_bresp_hold", bresp, 2'b00);
        end
        @(posedge clk); #1;
        write(4'h0, 32'h0BADBEEF, 4'b1100);
        @(negedge clk);
        check("t4_aw_held", awready, 0);
        check("t4_w_held", wready, 0);
        check("t4_bvalid_first", bvalid, 1);
        check("t4_reg0_pending", regs_out4[31:0], 32'h00000001);
        @(posedge clk); #1 bready = 1'b1;
        @(negedge clk);
        @(negedge clk) check("t4_gap", bvalid, 0);
        @(negedge clk) check("t4_b2", bvalid, 1);
        @(posedge clk); #1;
        drain();
        check("t4_reg0", regs_out4[31:0], 32'h0BAD0001);
        check_regs4("t4_regs_out");

        // 5: three-register build, out-of-range index
        sel = 1'b1;
        write(4'h0, 32'h00000055, 4'hF);
        write(4'hC, 32'hDEADBEEF, 4'hF);
        drain();
        read(4'hC);
        read(4'h0);
        read(4'h8);
        drain();
        check("t5_regs_out3", regs_out3, {32'h0, 32'h0, 32'h00000055});
        sel = 1'b0;

        // 6: reset with B and R pending
        bready = 1'b0; rready = 1'b0;
        write(4'h0, 32'h00000077, 4'hF);
        read(4'h4);
        n = 0;
        do begin @(negedge clk); n++; end while (!(bvalid && rvalid) && n < 50);
        check("t6_pending", {bvalid, rvalid}, 2'b11);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("t6_bvalid", bvalid, 0);
        check("t6_rvalid", rvalid, 0);
        check("t6_readies", {awready, wready, arready}, 0);
        check("t6_resp_data", {bresp, rresp, rdata}, 0);
        check("t6_regs_out", regs_out4, 0);
        b_q.delete(); r_q.delete();
        for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) m[i][k] = '0;
        @(negedge clk) begin rst_n = 1'b1; bready = 1'b1; rready = 1'b1; end
        @(posedge clk); #1;
        read(4'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
